dmem_loader: RTL and testbench

Host-side loader/unloader for the matrix-multiply RISC-V CPU's data memory. It streams matrix1 and matrix2 into data memory through a valid/ready input while holding the CPU in reset, then releases the CPU. After `done`, it reads the M×N2 result region back out through a valid/ready output. It sits between the host/FPGA I/O and the data-memory port muxed against `RISCVCPU`, and replaces hierarchical preload and readback with synthesizable hardware.

---
 rtl/dmem_loader.sv | 162 ++++++++++++++++
 tb/tb_dmem_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_loader.sv
// rtl/dmem_loader.sv - streams matrices into CPU data memory, runs the CPU, streams the result region back out
module dmem_loader #(
    parameter int M       = 100,
    parameter int N       = 50,
    parameter int N2      = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rst,
    input  logic              cpu_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              timed_out,
    output logic [31:0]       run_cycles
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(M*N + N*N2 - 1);
    localparam logic [ADDR_W-1:0] RES_BASE = ADDR_W'(M*N + N*N2);
    localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(M*N2 - 1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [31:0]       RUN_LAST = 32'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_RD     = 3'd4;
    localparam logic [2:0] S_LAT    = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;
    localparam logic [2:0] S_FINISH = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [31:0]       run_q, run_d;
    logic              to_q, to_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] odata_q, odata_d;

    assign in_ready   = (state_q == S_LOAD);
    assign out_valid  = (state_q == S_OUT);
    assign out_last   = (state_q == S_OUT) && (k_q == LAST_K);
    assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
    // CPU stays out of reset from RUN onward so its state remains observable after FINISH
    assign cpu_rst    = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_SETTLE);
    assign mem_we     = we_q;
    assign mem_re     = re_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign out_data   = odata_q;
    assign timed_out  = to_q;
    assign run_cycles = run_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        run_d   = run_q;
        to_d    = to_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        odata_d = odata_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    run_d   = '0;
                    to_d    = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = in_data;
                    idx_d   = idx_q + ONE_A;
                    if (idx_q == LAST_IDX) state_d = S_SETTLE;
                end
            end
            S_SETTLE: state_d = S_RUN;
            S_RUN: begin
                run_d = run_q + 32'd1;
                if (cpu_done) begin
                    state_d = S_RD;
                    k_d     = '0;
                    re_d    = 1'b1;
                    addr_d  = RES_BASE;
                end else if (run_q == RUN_LAST) begin
                    state_d = S_FINISH;
                    to_d    = 1'b1;
                end
            end
            S_RD: state_d = S_LAT;
            S_LAT: begin
                odata_d = mem_rdata;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (k_q == LAST_K) begin
                        state_d = S_FINISH;
                    end else begin
                        // Strobe is registered, so the read is launched on the transition into RD
                        state_d = S_RD;
                        k_d     = k_q + ONE_A;
                        re_d    = 1'b1;
                        addr_d  = RES_BASE + k_q + ONE_A;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            k_q     <= '0;
            run_q   <= '0;
            to_q    <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            run_q   <= run_d;
            to_q    <= to_d;
            we_q    <= we_d;
            re_q    <= re_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            odata_q <= odata_d;
        end
    end

endmodule

// File: tb/tb_dmem_loader.sv
// tb/tb_dmem_loader.sv - scoreboard bench for dmem_loader with a 2x2 by 2x2 matrix configuration
module tb_dmem_loader;

    localparam int M = 2, N = 2, N2 = 2, DW = 32, AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start_t, in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready = 1'b1;
    logic          in_ready, mem_we, mem_re, cpu_rst, out_valid, out_last, busy, timed_out;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, out_data, mem_rdata;
    logic [31:0]   run_cycles;
    logic          in_ready_t, mem_we_t, mem_re_t, cpu_rst_t, out_valid_t, out_last_t, busy_t, timed_out_t;
    logic [AW-1:0] mem_addr_t;
    logic [DW-1:0] mem_wdata_t, out_data_t;
    logic [31:0]   run_cycles_t;
    wire           cpu_done;

    dmem_loader #(.M(M), .N(N), .N2(N2), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(64)) dut (
        .CLOCK_50(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_rst(cpu_rst), .cpu_done(cpu_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .timed_out(timed_out), .run_cycles(run_cycles));

    // Second instance whose CPU never finishes, for the timeout path
    dmem_loader #(.M(M), .N(N), .N2(N2), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(16)) dut_t (
        .CLOCK_50(clk), .rst(rst), .start(start_t),
        .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data),
        .mem_we(mem_we_t), .mem_re(mem_re_t), .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_rdata(32'd0),
        .cpu_rst(cpu_rst_t), .cpu_done(1'b0),
        .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t), .out_last(out_last_t),
        .busy(busy_t), .timed_out(timed_out_t), .run_cycles(run_cycles_t));

    logic [DW-1:0] res_mem [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    always @(posedge clk)
        if (mem_re) mem_rdata <= (mem_addr >= 16'd8 && mem_addr < 16'd12) ? res_mem[mem_addr[1:0]] : 32'hDEADBEEF;

    int run_cnt = 0, done_at = 1;
    bit done_en = 1'b0;
    always @(posedge clk) run_cnt <= cpu_rst ? 0 : run_cnt + 1;
    assign cpu_done = done_en && (run_cnt >= done_at - 1);

    int n_chk = 0, n_fail = 0;
    int wr_cnt = 0, re_cnt = 0, re_cnt_t = 0, hold_cnt = 0, hs_cnt = 0, stall_cnt = 0;
    bit wr_chk_en = 1'b1, stall_en = 1'b0;
    logic [47:0] wr_q[$];
    logic [15:0] rd_q[$];
    logic [32:0] out_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Memory-side monitor
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
            if (busy && cpu_rst) hold_cnt++;
            if (mem_re_t) re_cnt_t++;
            if (mem_we) begin
                wr_cnt++;
                if (wr_chk_en) begin
                    if (wr_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL wr_extra: write to addr %0d, expected none", mem_addr);
                    end else begin
                        logic [47:0] e;
                        e = wr_q.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(e[47:32]));
                        check("wr_data", mem_wdata, e[31:0]);
                    end
                end
            end
            if (mem_re) begin
                re_cnt++;
                if (rd_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rd_extra: read of addr %0d, expected none", mem_addr);
                end else begin
                    check("rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
                end
            end
        end
    end

    // Output-side monitor; also owns out_ready so stalls and handshakes are decided in one place
    initial begin
        bit stall_chk;
        logic [DW-1:0] stall_data;
        logic stall_last;
        stall_chk = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (stall_chk) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", out_data, stall_data);
                    check("stall_last", 32'(out_last), 32'(stall_last));
                end
                stall_chk = 1'b0;
                if (out_valid && stall_en && hs_cnt == 1 && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                    stall_chk = 1'b1;
                    stall_data = out_data;
                    stall_last = out_last;
                end else begin
                    out_ready = 1'b1;
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (out_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL out_extra: output %0d, expected none", out_data);
                    end else begin
                        logic [32:0] e;
                        e = out_q.pop_front();
                        check("out_data", out_data, e[31:0]);
                        check("out_last", 32'(out_last), 32'(e[32]));
                    end
                end
            end
        end
    end

    task automatic pulse_start(input bit to_t);
        @(negedge clk);
        if (to_t) start_t = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_t = 1'b0;
    endtask

    task automatic stream(input int gap, input int base, input bit push, input bit to_t);
        for (int i = 0; i < 8; i++) begin
            int t;
            in_valid = 1'b1;
            in_data = 32'(base + i);
            if (push) wr_q.push_back({16'(i), 32'(base + i)});
            t = 0;
            while (!(to_t ? in_ready_t : in_ready) && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) fail_now("in_ready_wait");
            @(negedge clk);
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input bit to_t, input string name);
        int t;
        t = 0;
        while ((to_t ? busy_t : busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail_now(name);
    endtask

    task automatic expect_readback();
        rd_q = '{16'd8, 16'd9, 16'd10, 16'd11};
        out_q = '{{1'b0, 32'd19}, {1'b0, 32'd22}, {1'b0, 32'd43}, {1'b1, 32'd50}};
    endtask

    task automatic clear_counts();
        wr_cnt = 0; re_cnt = 0; hold_cnt = 0; hs_cnt = 0; stall_cnt = 0;
    endtask

    initial begin
        bit found;
        int v;
        rst = 1'b0; start = 1'b0; start_t = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timed_out", 32'(timed_out), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_run_cycles", run_cycles, 32'd0);
        rst = 1'b1;

        // Continuous load 1..8, CPU done on its 20th cycle, stall on result word 2
        clear_counts();
        stall_en = 1'b1; done_en = 1'b1; done_at = 20;
        expect_readback();
        pulse_start(1'b0);
        stream(0, 1, 1'b1, 1'b0);
        wait_idle(1'b0, "t1_finish");
        check("t1_writes", 32'(wr_cnt), 32'd8);
        check("t1_cpu_held_cycles", 32'(hold_cnt), 32'd9);
        check("t1_run_cycles", run_cycles, 32'd20);
        check("t1_timed_out", 32'(timed_out), 32'd0);
        check("t1_cpu_rst_finish", 32'(cpu_rst), 32'd0);
        check("t1_reads", 32'(re_cnt), 32'd4);
        check("t1_stall_cycles", 32'(stall_cnt), 32'd5);
        check("t1_out_left", 32'(out_q.size()), 32'd0);
        check("t1_wr_left", 32'(wr_q.size()), 32'd0);

        // Valid every third cycle, CPU done on its first cycle
        clear_counts();
        stall_en = 1'b0; done_at = 1;
        expect_readback();
        pulse_start(1'b0);
        stream(2, 11, 1'b1, 1'b0);
        wait_idle(1'b0, "t2_finish");
        check("t2_writes", 32'(wr_cnt), 32'd8);
        check("t2_run_cycles", run_cycles, 32'd1);
        check("t2_reads", 32'(re_cnt), 32'd4);
        check("t2_out_left", 32'(out_q.size()), 32'd0);
        check("t2_wr_left", 32'(wr_q.size()), 32'd0);

        // Timeout instance; the main instance sits in FINISH and must ignore the stream
        clear_counts();
        re_cnt_t = 0;
        pulse_start(1'b1);
        stream(0, 21, 1'b0, 1'b1);
        wait_idle(1'b1, "t3_finish");
        check("t3_run_cycles", run_cycles_t, 32'd16);
        check("t3_timed_out", 32'(timed_out_t), 32'd1);
        check("t3_reads", 32'(re_cnt_t), 32'd0);
        check("t3_cpu_rst", 32'(cpu_rst_t), 32'd0);
        check("t3_out_valid", 32'(out_valid_t), 32'd0);
        check("t3_out_last", 32'(out_last_t), 32'd0);
        check("t3_out_data", out_data_t, 32'd0);
        check("t3_mem_we", 32'(mem_we_t), 32'd0);
        check("t3_last_addr", 32'(mem_addr_t), 32'd7);
        check("t3_last_wdata", mem_wdata_t, 32'd28);
        check("t3_main_ignored", 32'(wr_cnt), 32'd0);

        // Reset during the 4th write of a load, then reload from address 0
        wr_chk_en = 1'b0;
        pulse_start(1'b0);
        in_valid = 1'b1;
        v = 101;
        in_data = 32'(v);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 16'd3) found = 1'b1;
            else if (in_ready) begin
                v++;
                in_data = 32'(v);
            end
        end
        check("t4_found_4th_write", 32'(found), 32'd1);
        check("t4_4th_wdata", mem_wdata, 32'd104);
        #2 rst = 1'b0;
        #1;
        check("t4_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t4_in_ready", 32'(in_ready), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_mem_we", 32'(mem_we), 32'd0);
        check("t4_mem_addr", 32'(mem_addr), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wr_q.delete();
        wr_chk_en = 1'b1;
        clear_counts();
        expect_readback();
        pulse_start(1'b0);
        stream(0, 201, 1'b1, 1'b0);
        wait_idle(1'b0, "t4_finish");
        check("t4_writes", 32'(wr_cnt), 32'd8);
        check("t4_wr_left", 32'(wr_q.size()), 32'd0);
        check("t4_out_left", 32'(out_q.size()), 32'd0);
        check("t4_timed_out", 32'(timed_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
